if_stage: RTL and testbench
===========================

# if_stage

Instruction-fetch stage feeding the decode stage of the RV32I core. Holds the program counter, fetches one 32-bit instruction word at a time over a request/acknowledge instruction-memory port, and presents it with its PC to decode until decode accepts it. Redirects to the resolved branch/jump target on acceptance and traps on a misaligned target.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0
- NOP_INSTR, 32'h0000_0013, instruction word driven while no valid instruction is held (addi x0,x0,0)

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- imem_req_o  out  1  fetch request
- imem_addr_o  out  32  fetch byte address; equals pc_o
- imem_ack_i  in  1  memory acknowledge; imem_rdata_i valid in this cycle
- imem_rdata_i  in  32  fetched instruction word
- stall_i  in  1  decode/execute cannot accept this cycle
- br_taken_i  in  1  current instruction redirects the PC (taken branch, JAL, JALR)
- br_target_i  in  32  redirect target byte address
- instr_data_o  out  32  held instruction (to decode instr_data_i)
- instr_valid_o  out  1  instr_data_o/pc_o describe a valid instruction
- pc_o  out  32  PC of the held or in-flight instruction
- pc_plus4_o  out  32  pc_o + 4 (link value for JAL/JALR)
- misalign_o  out  1  sticky misaligned-target trap flag

## Operation
- States: START, FETCH, HOLD, TRAP.
- START: entered on rst. imem_req_o=0, instr_valid_o=0. Next cycle -> FETCH unconditionally.
- FETCH: imem_req_o=1, imem_addr_o=pc_o held stable. On imem_ack_i=1: instr_data_o <= imem_rdata_i, -> HOLD. Otherwise remain. stall_i, br_taken_i ignored.
- HOLD: imem_req_o=0, instr_valid_o=1. Accept = !stall_i. On accept:
  - br_taken_i=0: pc <= pc+4 (mod 2^32, wraps 32'hFFFF_FFFC -> 0), -> FETCH.
  - br_taken_i=1, br_target_i[1:0]==0: pc <= br_target_i, -> FETCH.
  - br_taken_i=1, br_target_i[1:0]!=0: pc unchanged, misalign_o <= 1, -> TRAP.
  - On stall: pc, instr_data_o unchanged; br_taken_i/br_target_i ignored.
- TRAP: imem_req_o=0, instr_valid_o=0, instr_data_o=NOP_INSTR, pc_o holds faulting instruction's PC. Exited only by rst.
- instr_data_o = NOP_INSTR whenever not in HOLD; captured word shown only in HOLD.
- pc_plus4_o = pc_o + 4, combinational, 32-bit wrap.
- Late ack/rdata changes outside FETCH ignored.

## Timing
- Reset values (cycle after rst sampled high): state START, pc_o=RESET_PC, pc_plus4_o=RESET_PC+4, instr_data_o=NOP_INSTR, instr_valid_o=0, imem_req_o=0, misalign_o=0.
- rst has priority over every other input in every state, including mid-fetch (outstanding request dropped; memory must tolerate req deassertion).
- First request: cycle after START.
- Zero-wait memory (ack in first FETCH cycle): instr_valid_o high next cycle; unstalled throughput one instruction per 2 cycles.
- N-cycle ack latency: N+1 cycles FETCH->HOLD.
- Redirect takes effect on accept edge; next FETCH uses target; no wrong-path instruction ever presented.
- br_taken_i and stall_i both high in HOLD: stall wins, redirect re-evaluated next accept cycle.

## Test plan
- Reset: rst high 2 cycles, RESET_PC=0 -> pc_o=0, pc_plus4_o=4, instr_valid_o=0, imem_req_o=0, instr_data_o=32'h00000013; req=1 addr=0 one cycle after rst low.
- Sequential, zero-wait memory, stall_i=0: ack every FETCH -> instr_valid_o on alternate cycles with pc_o 0,4,8,12, instr_data_o matches memory words.
- Wait states + stall: ack after 3 cycles, then stall_i=1 for 4 cycles -> imem_addr_o stable during wait, instr_data_o/pc_o frozen during stall, pc advances by 4 only after stall drops.
- Taken branch: at pc_o=0x10, br_taken_i=1, br_target_i=0x40 -> next imem_addr_o=0x40, pc_plus4_o=0x44; then br_taken_i with stall_i=1 -> no redirect until stall drops.
- Misaligned target: br_target_i=0x42 on accept -> TRAP, misalign_o=1, instr_valid_o=0, imem_req_o=0, pc_o=faulting PC; remains until rst, rst clears misalign_o.
- Wrap and mid-fetch reset: RESET_PC=32'hFFFF_FFFC sequential accept -> pc_o=0; rst asserted during FETCH with ack pending -> returns to reset values, stale ack ignored.

Source files
------------

// File: rtl/if_stage.sv
// -----------------------------------------------------------------------------
// if_stage -- instruction-fetch stage of the RV32I core.
//
// Holds the program counter and fetches one 32-bit instruction word at a time
// over a request/acknowledge instruction-memory port. The fetched word is
// presented to decode together with its PC until decode accepts it. On
// acceptance the PC either advances by 4 or is redirected to a resolved
// branch/jump target. A misaligned target raises a sticky trap that only
// reset clears.
//
// Ports:
//   clk           in   1   clock, all state updates on the rising edge
//   rst           in   1   synchronous active-high reset
//   imem_req_o    out  1   fetch request (high only while fetching)
//   imem_addr_o   out  32  fetch byte address, always equal to pc_o
//   imem_ack_i    in   1   memory acknowledge, imem_rdata_i valid this cycle
//   imem_rdata_i  in   32  fetched instruction word
//   stall_i       in   1   decode/execute cannot accept this cycle
//   br_taken_i    in   1   held instruction redirects the PC
//   br_target_i   in   32  redirect target byte address
//   instr_data_o  out  32  held instruction, NOP_INSTR when nothing is valid
//   instr_valid_o out  1   instr_data_o/pc_o describe a valid instruction
//   pc_o          out  32  PC of the held or in-flight instruction
//   pc_plus4_o    out  32  pc_o + 4 (link value for JAL/JALR)
//   misalign_o    out  1   sticky misaligned-target trap flag
// -----------------------------------------------------------------------------
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        stall_i,
    input  logic        br_taken_i,
    input  logic [31:0] br_target_i,
    output logic [31:0] instr_data_o,
    output logic        instr_valid_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o,
    output logic        misalign_o
);

    typedef enum logic [1:0] {
        ST_START = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2,
        ST_TRAP  = 2'd3
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic [31:0] pc_r;
    logic [31:0] pc_s;
    logic [31:0] instr_r;
    logic [31:0] instr_s;
    logic        misalign_r;
    logic        misalign_s;

    // Registered copies of the decode-facing and memory-facing controls.
    logic        req_r;
    logic        valid_r;
    logic [31:0] data_out_r;

    // A target is unusable for a 32-bit fetch unless word aligned.
    function automatic logic is_misaligned(input logic [31:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

    // Next-state, next-PC and capture logic for the fetch FSM.
    always_comb begin
        state_s    = state_r;
        pc_s       = pc_r;
        instr_s    = instr_r;
        misalign_s = misalign_r;
        case (state_r)
            ST_START: begin
                state_s = ST_FETCH;
            end
            ST_FETCH: begin
                // Branch and stall inputs are meaningless until a word is held.
                if (imem_ack_i) begin
                    instr_s = imem_rdata_i;
                    state_s = ST_HOLD;
                end else begin
                    state_s = ST_FETCH;
                end
            end
            ST_HOLD: begin
                // A stall freezes everything; a pending redirect is simply
                // re-evaluated on the cycle decode finally accepts.
                if (!stall_i) begin
                    if (!br_taken_i) begin
                        pc_s    = pc_r + 32'd4;
                        state_s = ST_FETCH;
                    end else if (is_misaligned(br_target_i)) begin
                        // PC keeps the faulting instruction's address.
                        misalign_s = 1'b1;
                        state_s    = ST_TRAP;
                    end else begin
                        pc_s    = br_target_i;
                        state_s = ST_FETCH;
                    end
                end else begin
                    state_s = ST_HOLD;
                end
            end
            ST_TRAP: begin
                state_s = ST_TRAP;
            end
            default: begin
                state_s = ST_START;
            end
        endcase
    end

    // State, PC, capture and output registers; reset dominates every state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_START;
            pc_r       <= RESET_PC;
            instr_r    <= NOP_INSTR;
            misalign_r <= 1'b0;
            req_r      <= 1'b0;
            valid_r    <= 1'b0;
            data_out_r <= NOP_INSTR;
        end else begin
            state_r    <= state_s;
            pc_r       <= pc_s;
            instr_r    <= instr_s;
            misalign_r <= misalign_s;
            // Outputs are registered from the next state so they line up
            // with state_r without combinational decode on the ports.
            req_r      <= (state_s == ST_FETCH);
            valid_r    <= (state_s == ST_HOLD);
            data_out_r <= (state_s == ST_HOLD) ? instr_s : NOP_INSTR;
        end
    end

    assign imem_req_o    = req_r;
    assign imem_addr_o   = pc_r;
    assign instr_valid_o = valid_r;
    assign instr_data_o  = data_out_r;
    assign pc_o          = pc_r;
    assign pc_plus4_o    = pc_r + 32'd4;
    assign misalign_o    = misalign_r;

endmodule

// File: tb/tb_if_stage.sv
// -----------------------------------------------------------------------------
// tb_if_stage -- self-checking bench for if_stage.
//
// A table of per-instruction records (address expected, memory wait states,
// stall cycles, branch decision) drives the main DUT; the expected {pc, word}
// pair is pushed into a scoreboard when the memory acknowledges and popped
// when the DUT presents the instruction. Hand-written sequences cover the
// trap, reset-during-fetch and PC wrap corner cases (the latter on a second
// instance with RESET_PC = 32'hFFFF_FFFC).
// -----------------------------------------------------------------------------
module tb_if_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        br_taken;
    logic [31:0] br_target;
    logic [31:0] instr_data;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        misalign;

    logic        rst1;
    logic        imem_req1;
    logic [31:0] imem_addr1;
    logic        imem_ack1;
    logic [31:0] imem_rdata1;
    logic [31:0] instr_data1;
    logic        instr_valid1;
    logic [31:0] pc1;
    logic [31:0] pc_plus41;
    logic        misalign1;
    logic        stall1;
    logic        br_taken1;
    logic [31:0] br_target1;

    int n_cmp;
    int n_bad;

    if_stage dut (
        .clk(clk), .rst(rst),
        .imem_req_o(imem_req), .imem_addr_o(imem_addr),
        .imem_ack_i(imem_ack), .imem_rdata_i(imem_rdata),
        .stall_i(stall), .br_taken_i(br_taken), .br_target_i(br_target),
        .instr_data_o(instr_data), .instr_valid_o(instr_valid),
        .pc_o(pc), .pc_plus4_o(pc_plus4), .misalign_o(misalign)
    );

    if_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst(rst1),
        .imem_req_o(imem_req1), .imem_addr_o(imem_addr1),
        .imem_ack_i(imem_ack1), .imem_rdata_i(imem_rdata1),
        .stall_i(stall1), .br_taken_i(br_taken1), .br_target_i(br_target1),
        .instr_data_o(instr_data1), .instr_valid_o(instr_valid1),
        .pc_o(pc1), .pc_plus4_o(pc_plus41), .misalign_o(misalign1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] exp_pc;
        int          wait_cycles;
        int          stall_cycles;
        logic        br;
        logic [31:0] tgt;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
    } sb_t;

    sb_t sb[$];

    // Memory contents: distinct, never equal to the NOP encoding.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hC0DE_0000 ^ {a[15:0], a[15:0]} ^ 32'h0000_0100;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tbl[7];
        sb_t  e;
        n_cmp = 0;
        n_bad = 0;

        tbl[0] = '{32'h0000_0000, 0, 0, 1'b0, 32'h0};
        tbl[1] = '{32'h0000_0004, 0, 0, 1'b0, 32'h0};
        tbl[2] = '{32'h0000_0008, 0, 0, 1'b0, 32'h0};
        tbl[3] = '{32'h0000_000C, 3, 4, 1'b0, 32'h0};
        tbl[4] = '{32'h0000_0010, 0, 2, 1'b1, 32'h0000_0040};
        tbl[5] = '{32'h0000_0040, 0, 0, 1'b0, 32'h0};
        tbl[6] = '{32'h0000_0044, 1, 0, 1'b1, 32'h0000_0042};

        rst = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0;
        stall = 1'b0; br_taken = 1'b0; br_target = 32'h0;
        rst1 = 1'b1; imem_ack1 = 1'b0; imem_rdata1 = 32'h0;
        stall1 = 1'b0; br_taken1 = 1'b0; br_target1 = 32'h0;

        // Reset held for two cycles.
        cyc();
        cyc();
        check("rst_pc", pc, 32'h0);
        check("rst_pc_plus4", pc_plus4, 32'h4);
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_instr", instr_data, NOP);
        check("rst_misalign", {31'd0, misalign}, 32'd0);
        rst = 1'b0;
        cyc();

        // Table-driven fetch/accept sequence.
        for (int i = 0; i < 7; i++) begin
            check("fetch_req", {31'd0, imem_req}, 32'd1);
            check("fetch_addr", imem_addr, tbl[i].exp_pc);
            check("fetch_pc_plus4", pc_plus4, tbl[i].exp_pc + 32'd4);
            check("fetch_valid", {31'd0, instr_valid}, 32'd0);
            check("fetch_instr", instr_data, NOP);
            for (int w = 0; w < tbl[i].wait_cycles; w++) begin
                imem_ack = 1'b0;
                cyc();
                check("wait_req", {31'd0, imem_req}, 32'd1);
                check("wait_addr", imem_addr, tbl[i].exp_pc);
            end
            imem_ack = 1'b1;
            imem_rdata = mem_word(imem_addr);
            sb.push_back('{tbl[i].exp_pc, mem_word(tbl[i].exp_pc)});
            cyc();
            imem_ack = 1'b0;
            imem_rdata = 32'hDEAD_BEEF;
            if (sb.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL scoreboard_empty: got 0 entries expected 1");
            end else begin
                e = sb.pop_front();
                check("hold_valid", {31'd0, instr_valid}, 32'd1);
                check("hold_req", {31'd0, imem_req}, 32'd0);
                check("hold_pc", pc, e.pc);
                check("hold_pc_plus4", pc_plus4, e.pc + 32'd4);
                check("hold_instr", instr_data, e.word);
                for (int s = 0; s < tbl[i].stall_cycles; s++) begin
                    stall = 1'b1;
                    br_taken = tbl[i].br;
                    br_target = tbl[i].tgt;
                    imem_ack = 1'b1;
                    cyc();
                    imem_ack = 1'b0;
                    check("stall_valid", {31'd0, instr_valid}, 32'd1);
                    check("stall_pc", pc, e.pc);
                    check("stall_instr", instr_data, e.word);
                end
            end
            stall = 1'b0;
            br_taken = tbl[i].br;
            br_target = tbl[i].tgt;
            cyc();
            br_taken = 1'b0;
            br_target = 32'h0;
        end

        // Misaligned target taken from 0x44: trap holds until reset.
        for (int t = 0; t < 3; t++) begin
            check("trap_misalign", {31'd0, misalign}, 32'd1);
            check("trap_valid", {31'd0, instr_valid}, 32'd0);
            check("trap_req", {31'd0, imem_req}, 32'd0);
            check("trap_pc", pc, 32'h0000_0044);
            check("trap_instr", instr_data, NOP);
            imem_ack = 1'b1;
            imem_rdata = 32'h1234_5678;
            br_taken = 1'b1;
            br_target = 32'h0000_0080;
            cyc();
        end
        imem_ack = 1'b0;
        br_taken = 1'b0;
        rst = 1'b1;
        cyc();
        check("trap_rst_misalign", {31'd0, misalign}, 32'd0);
        check("trap_rst_pc", pc, 32'h0);
        rst = 1'b0;
        cyc();
        check("refetch_addr", imem_addr, 32'h0);
        check("refetch_req", {31'd0, imem_req}, 32'd1);

        // Reset during a pending fetch; stale ack arrives during START.
        imem_ack = 1'b0;
        cyc();
        rst = 1'b1;
        imem_ack = 1'b1;
        imem_rdata = 32'hBAD0_BAD0;
        cyc();
        check("midrst_req", {31'd0, imem_req}, 32'd0);
        check("midrst_valid", {31'd0, instr_valid}, 32'd0);
        check("midrst_instr", instr_data, NOP);
        rst = 1'b0;
        cyc();
        imem_ack = 1'b0;
        check("stale_valid", {31'd0, instr_valid}, 32'd0);
        check("stale_req", {31'd0, imem_req}, 32'd1);
        check("stale_addr", imem_addr, 32'h0);
        cyc();
        check("stale_still_fetch", {31'd0, instr_valid}, 32'd0);

        // PC wrap on the second instance.
        rst1 = 1'b0;
        cyc();
        check("wrap_addr", imem_addr1, 32'hFFFF_FFFC);
        check("wrap_pc_plus4", pc_plus41, 32'h0);
        imem_ack1 = 1'b1;
        imem_rdata1 = mem_word(32'hFFFF_FFFC);
        cyc();
        imem_ack1 = 1'b0;
        check("wrap_hold_valid", {31'd0, instr_valid1}, 32'd1);
        check("wrap_hold_instr", instr_data1, mem_word(32'hFFFF_FFFC));
        cyc();
        check("wrap_pc", pc1, 32'h0);
        check("wrap_req", {31'd0, imem_req1}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
